// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle RV32I core: fetch, decode, execute, memory, writeback.
// Outputs are decoded from the state register; memory strobes respect a request/ready handshake.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_source,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJal    = 4'd10,
        StTrap   = 4'd11
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    logic mem_req_raw, mem_we_raw, ir_write_raw, pc_write_raw, reg_write_raw, done_raw;
    logic branch_taken;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExecR,
            StExecI:  state_d = StAluWb;
            StMemWb,
            StAluWb,
            StBranch,
            StJal:    state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    // Sticky flag: set on entry to TRAP, cleared only by reset.
    assign illegal_d = illegal_q | (state_d == StTrap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign branch_taken = ((funct3 == 3'b000) &  zero) |
                          ((funct3 == 3'b001) & ~zero);

    always_comb begin
        mem_req_raw   = 1'b0;
        mem_we_raw    = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        done_raw      = 1'b0;
        iord          = 1'b0;
        pc_source     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        unique case (state_q)
            StFetch: begin
                mem_req_raw  = 1'b1;
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_req_raw = 1'b1;
                iord        = 1'b1;
            end
            StMemWb: begin
                reg_write_raw = 1'b1;
                result_src    = 2'b01;
                done_raw      = 1'b1;
            end
            StMemWr: begin
                mem_req_raw = 1'b1;
                mem_we_raw  = 1'b1;
                iord        = 1'b1;
                done_raw    = mem_ready;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                aluop     = 2'b11;
            end
            StAluWb: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            StBranch: begin
                alu_src_a    = 2'b10;
                aluop        = 2'b01;
                pc_source    = 1'b1;
                pc_write_raw = branch_taken;
                done_raw     = 1'b1;
            end
            StJal: begin
                pc_source     = 1'b1;
                pc_write_raw  = 1'b1;
                reg_write_raw = 1'b1;
                result_src    = 2'b10;
                done_raw      = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held, even before the first clock edge.
    assign mem_req    = mem_req_raw   & rst_n;
    assign mem_we     = mem_we_raw    & rst_n;
    assign ir_write   = ir_write_raw  & rst_n;
    assign pc_write   = pc_write_raw  & rst_n;
    assign reg_write  = reg_write_raw & rst_n;
    assign instr_done = done_raw      & rst_n;
    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table-driven instruction runs, hand-written
// reset corner cases and randomized instruction streams against a per-instruction state plan.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_source, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, aluop;
    logic       instr_done, illegal_op;
    logic [3:0] state_dbg;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_source;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        bit         z;
        int         fetch_waits;
        int         mem_waits;
        int         exp_cycles;
        int         exp_pcw_last;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string name, input outs_t got, input outs_t exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Expected outputs for a given state, straight from the per-state output tables.
    function automatic outs_t model_outs(int st, bit rdy, bit z, logic [2:0] f3, bit rstn);
        outs_t o;
        o = '0;
        o.state = 4'(st);
        o.illegal_op = (st == 11);
        case (st)
            0: begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
            2: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; end
            3: begin o.mem_req = 1; o.iord = 1; end
            4: begin o.reg_write = 1; o.result_src = 2'b01; o.instr_done = 1; end
            5: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.instr_done = rdy; end
            6: begin o.alu_src_a = 2'b10; o.aluop = 2'b10; end
            7: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; o.aluop = 2'b11; end
            8: begin o.reg_write = 1; o.instr_done = 1; end
            9: begin
                o.alu_src_a = 2'b10; o.aluop = 2'b01; o.pc_source = 1; o.instr_done = 1;
                o.pc_write = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
            end
            10: begin
                o.pc_source = 1; o.pc_write = 1; o.reg_write = 1;
                o.result_src = 2'b10; o.instr_done = 1;
            end
            default: ;
        endcase
        if (!rstn) begin
            o.mem_req = 0; o.mem_we = 0; o.ir_write = 0;
            o.pc_write = 0; o.reg_write = 0; o.instr_done = 0;
        end
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_source, reg_write, result_src,
                alu_src_a, alu_src_b, aluop, instr_done, illegal_op, state_dbg};
    endfunction

    // Drive one cycle's inputs, compare just before the next edge, then advance past the edge.
    task automatic step(input int st, input bit rdy, input bit z, input bit rstn, output outs_t g);
        mem_ready = rdy;
        zero      = z;
        rst_n     = rstn;
        @(negedge clk);
        g = dut_outs();
        chk_outs($sformatf("cyc_st%0d", st), g, model_outs(st, rdy, z, funct3, rstn));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_from(input int st);
        outs_t g;
        step(st, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, g);
        chk("illegal_cleared", int'(illegal_op), 0);
        chk("reset_to_fetch", int'(state_dbg), 0);
    endtask

    // Sequence of states an instruction visits, by class.
    task automatic build_plan(input logic [6:0] op, output int plan[$]);
        plan = {0, 1};
        case (op)
            7'b0000011: plan = {plan, 2, 3, 4};
            7'b0100011: plan = {plan, 2, 5};
            7'b0110011: plan = {plan, 6, 8};
            7'b0010011: plan = {plan, 7, 8};
            7'b1100011: plan = {plan, 9};
            7'b1101111: plan = {plan, 10};
            default:    plan = {plan, 11};
        endcase
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit z,
                             input int fw, input int mw, input bit rnd,
                             output int cycles, output int pcw_last, output int dones);
        int    plan[$];
        outs_t g;
        bit    rdy, zz, is_mem;
        int    w;
        opcode = op;
        funct3 = f3;
        cycles = 0; pcw_last = 0; dones = 0;
        build_plan(op, plan);
        foreach (plan[i]) begin
            if (plan[i] == 11) begin
                for (int k = 0; k < 12; k++) begin
                    step(11, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b1, g);
                    cycles++;
                    dones += int'(g.instr_done);
                end
                continue;
            end
            w = 0;
            is_mem = (plan[i] == 0) || (plan[i] == 3) || (plan[i] == 5);
            forever begin
                if (is_mem)
                    rdy = rnd ? ($urandom_range(0, 2) != 0) : (w >= ((plan[i] == 0) ? fw : mw));
                else
                    rdy = ($urandom_range(0, 1) == 1);
                zz = rnd ? ($urandom_range(0, 1) == 1) : z;
                step(plan[i], rdy, zz, 1'b1, g);
                cycles++;
                dones += int'(g.instr_done);
                pcw_last = int'(g.pc_write);
                if (!is_mem || rdy) break;
                w++;
                if (w > 60) begin
                    chk("wait_budget", w, 60);
                    break;
                end
            end
        end
    endtask

    vec_t vecs[$];
    logic [6:0] op_pool[8];

    initial begin
        outs_t g;
        int cyc, pcw, dn;

        vecs = '{
            '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 0},
            '{7'b0000011, 3'd2, 1'b0, 0, 2, 7, 0},
            '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1},
            '{7'b1100011, 3'd0, 1'b0, 0, 0, 3, 0},
            '{7'b1100011, 3'd1, 1'b0, 0, 0, 3, 1},
            '{7'b1100011, 3'd1, 1'b1, 0, 0, 3, 0},
            '{7'b1100011, 3'd4, 1'b1, 0, 0, 3, 0},
            '{7'b0100011, 3'd2, 1'b0, 0, 0, 4, 0},
            '{7'b1101111, 3'd0, 1'b0, 0, 0, 3, 1},
            '{7'b0010011, 3'd0, 1'b0, 1, 0, 5, 0},
            '{7'b0100011, 3'd2, 1'b0, 0, 3, 7, 0},
            '{7'b0000011, 3'd2, 1'b0, 2, 0, 7, 0},
            '{7'b0000011, 3'd2, 1'b0, 0, 0, 5, 0}
        };
        op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                    7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct3 = '0;
        #1;
        chk("pre_reset_strobes",
            int'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}), 0);
        @(posedge clk);
        #1;
        reset_from(0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].fetch_waits,
                      vecs[i].mem_waits, 1'b0, cyc, pcw, dn);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            chk($sformatf("vec%0d_pcw_last", i), pcw, vecs[i].exp_pcw_last);
            chk($sformatf("vec%0d_done_cnt", i), dn, 1);
        end

        // Illegal opcode parks in TRAP until a single reset edge.
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0, cyc, pcw, dn);
        chk("trap_done_cnt", dn, 0);
        chk("trap_sticky", int'(illegal_op), 1);
        reset_from(11);

        // Reset while a store is stalled: strobes drop in the same cycle.
        opcode = 7'b0100011; funct3 = 3'd2;
        step(0, 1'b1, 1'b0, 1'b1, g);
        step(1, 1'b0, 1'b0, 1'b1, g);
        step(2, 1'b0, 1'b0, 1'b1, g);
        step(5, 1'b0, 1'b0, 1'b1, g);
        step(5, 1'b0, 1'b0, 1'b1, g);
        step(5, 1'b0, 1'b0, 1'b0, g);
        chk("abort_mem_we", int'(g.mem_we), 0);
        step(0, 1'b0, 1'b0, 1'b1, g);
        step(0, 1'b1, 1'b0, 1'b1, g);
        step(1, 1'b1, 1'b0, 1'b1, g);
        step(2, 1'b1, 1'b0, 1'b1, g);
        step(5, 1'b1, 1'b0, 1'b1, g);

        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            op = op_pool[$urandom_range(0, 7)];
            run_instr(op, 3'($urandom_range(0, 7)), 1'b0, 0, 0, 1'b1, cyc, pcw, dn);
            if (op == 7'b1111111 || op == 7'b0000000) begin
                chk("rand_trap_done", dn, 0);
                reset_from(11);
            end else begin
                chk("rand_done_cnt", dn, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
